ts_array_model: RTL and testbench
=================================

# ts_array_model

Parametrised, clocked behavioural model of the analog compute-in-memory column array. It adds addressed SRAM write/read ports, signed ternary row drive, a sequenced precharge/integrate/convert flow with start/done handshake, and a programmable ADC shift with saturation. It sits between the array controller and the digital post-processing path, where the single-column model sits today.

## Interface
- numRows, 128, word lines (rows) in the array
- numCols, 8, bit lines (columns); one ADC per column
- numAdcBits, 4, ADC output bits per column, two's complement
- numConvCycles, 2, ADC conversion length in cycles (>=1)
- CLK  in  1  the single clock; all state changes on its rising edge
- NRST  in  1  reset, asynchronous assert, active-low
- WR_EN  in  1  write strobe
- WR_ADDR  in  $clog2(numRows)  write row address
- WR_DATA  in  numCols  write data, bit j to column j
- WR_ERR  out  1  one-cycle pulse: write dropped (busy or address out of range)
- RD_EN  in  1  read strobe
- RD_ADDR  in  $clog2(numRows)  read row address
- RD_DATA  out  numCols  read data (sense-amp output)
- RD_VALID  out  1  one-cycle pulse, RD_DATA valid
- MAC_START  in  1  start request, accepted only in IDLE
- MAC_POS  in  numRows  rows driven at +1
- MAC_NEG  in  numRows  rows driven at -1
- ADC_SHIFT  in  4  arithmetic right shift before saturation
- MAC_BUSY  out  1  high in every state except IDLE
- MAC_DONE  out  1  one-cycle pulse, ADC_OUT updated
- ADC_OUT  out  numAdcBits*numCols  column j at bits [j*numAdcBits +: numAdcBits]

## Operation
- Memory: numRows x numCols bits; cleared to 0 by reset.
- Write: WR_EN sampled high, address < numRows, MAC_BUSY low -> row written at that edge. Otherwise no write and WR_ERR pulses next cycle.
- Read: allowed in any state. RD_EN sampled -> RD_DATA and RD_VALID on the next cycle. Out-of-range address returns 0. A read and write to the same row on the same edge returns the old data. RD_DATA holds until the next read.
- FSM states: IDLE -> PRE (1 cycle) -> INT (1 cycle) -> CONV (numConvCycles cycles) -> DONE (1 cycle) -> IDLE.
- MAC_START in IDLE latches MAC_POS, MAC_NEG and ADC_SHIFT. MAC_START in any other state is ignored.
- INT computes, per column j: sum_j = sum over i of (pos_i - neg_i) * mem[i][j].
  - A row with pos_i = neg_i = 1 contributes 0.
  - Sum is signed, width $clog2(numRows)+2; range [-numRows, numRows].
- CONV: code_j = sum_j >>> shift (arithmetic, floor toward minus infinity).
  - Saturate to [-2^(numAdcBits-1), 2^(numAdcBits-1)-1].
- DONE: ADC_OUT loaded with all codes and MAC_DONE high. ADC_OUT holds until the next DONE.
- Writes are blocked while busy, so INT always sees a stable array.

## Timing
- Reset: FSM IDLE; ADC_OUT, RD_DATA = 0; RD_VALID, WR_ERR, MAC_BUSY, MAC_DONE = 0.
- Start accepted on edge k. Then:
  - PRE during cycle k+1; INT during k+2.
  - CONV during k+3 .. k+2+numConvCycles.
  - MAC_DONE high during cycle k+3+numConvCycles; with defaults that is 5 cycles after the start edge.
- MAC_BUSY rises the cycle after the accepting edge and falls with the exit from DONE.
- MAC_START sampled during DONE is ignored. The earliest new start is the first IDLE cycle, giving back-to-back period 4+numConvCycles.
- NRST asserted mid-operation: immediate return to IDLE, outputs to reset values, memory cleared, no MAC_DONE.
- Reads during MAC operation keep the 1-cycle latency.

## Test plan
- Write 0xFF to rows 0-9. MAC_POS = rows 0-9, shift 0 -> MAC_DONE 5 cycles after start; each ADC_OUT column = 7 (sum 10 saturates). Shift 1 -> 5.
- Same data, MAC_NEG = rows 0-9. Shift 0 -> each column = -8 (0x8). Shift 2 -> -3 (0xD).
- Row 3 = 0x0F, row 4 = 0xF0. Set POS rows 3,4 and NEG row 4, plus POS and NEG both set on row 3 -> columns 0-3 = 0, columns 4-7 = 0.
- Write row 5 = 0xA5 then read row 5 -> RD_DATA 0xA5 with RD_VALID one cycle after RD_EN. Same-edge write 0x5A and read of row 5 -> returns 0xA5.
- Start a MAC, then pulse WR_EN during CONV -> WR_ERR pulses and the row is unchanged. Pulse MAC_START during CONV -> ignored, exactly one MAC_DONE.
- Assert NRST during INT -> MAC_BUSY = 0 and ADC_OUT = 0 immediately, no MAC_DONE. Reads after release return 0.

Source files
------------

// File: rtl/ts_array_model.sv
`default_nettype none
// ============================================================================
//  Module   : ts_array_model
//  Purpose  : Clocked behavioural model of the analog compute-in-memory
//             column array. It provides addressed SRAM write/read ports and
//             signed ternary row drive. A precharge/integrate/convert
//             sequence is started by a handshake, and each column has a
//             programmable ADC shift followed by saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module ts_array_model #(
    parameter int numRows       = 128,
    parameter int numCols       = 8,
    parameter int numAdcBits    = 4,
    parameter int numConvCycles = 2
) (
    input  logic                           CLK,
    input  logic                           NRST,
    input  logic                           WR_EN,
    input  logic [$clog2(numRows)-1:0]     WR_ADDR,
    input  logic [numCols-1:0]             WR_DATA,
    output logic                           WR_ERR,
    input  logic                           RD_EN,
    input  logic [$clog2(numRows)-1:0]     RD_ADDR,
    output logic [numCols-1:0]             RD_DATA,
    output logic                           RD_VALID,
    input  logic                           MAC_START,
    input  logic [numRows-1:0]             MAC_POS,
    input  logic [numRows-1:0]             MAC_NEG,
    input  logic [3:0]                     ADC_SHIFT,
    output logic                           MAC_BUSY,
    output logic                           MAC_DONE,
    output logic [numAdcBits*numCols-1:0]  ADC_OUT
);

    localparam int c_AW = $clog2(numRows);
    localparam int c_SW = $clog2(numRows) + 2;          // signed column-sum width
    localparam int c_CW = $clog2(numConvCycles + 1);    // conversion counter width

    localparam logic [c_AW:0]            c_NROWS     = (c_AW+1)'(numRows);
    localparam logic [c_CW-1:0]          c_CONV_LAST = c_CW'(numConvCycles - 1);
    localparam logic signed [c_SW-1:0]   c_CODE_MAX  = c_SW'(2**(numAdcBits-1) - 1);
    localparam logic signed [c_SW-1:0]   c_CODE_MIN  = c_SW'(-(2**(numAdcBits-1)));
    localparam logic signed [c_SW-1:0]   c_ONE       = c_SW'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_INT  = 3'd2,
        S_CONV = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic                            w_busy;
    logic                            w_done;
    logic                            w_accept;
    logic [c_CW-1:0]                 r_conv_cnt;

    logic [numCols-1:0]              r_mem [numRows];
    logic [numRows-1:0]              r_pos;
    logic [numRows-1:0]              r_neg;
    logic [3:0]                      r_shift;
    logic signed [c_SW-1:0]          r_sum [numCols];
    logic signed [c_SW-1:0]          w_sum [numCols];
    logic signed [c_SW-1:0]          w_shr [numCols];
    logic [numAdcBits*numCols-1:0]   w_code;
    logic [numAdcBits*numCols-1:0]   r_adc_out;

    logic [numCols-1:0]              r_rd_data;
    logic                            r_rd_valid;
    logic                            r_wr_err;
    logic                            w_wr_ok;
    logic                            w_rd_in_range;

    // Writes land only while idle so integration always sees a frozen array.
    assign w_wr_ok       = WR_EN && ({1'b0, WR_ADDR} < c_NROWS) && (r_state == S_IDLE);
    assign w_rd_in_range = ({1'b0, RD_ADDR} < c_NROWS);

    // Sequencer state register.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Sequencer next-state, busy/done flags and start acceptance.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (MAC_START) begin
                    w_accept     = 1'b1;
                    w_state_next = S_PRE;
                end
            end
            S_PRE:  w_state_next = S_INT;
            S_INT:  w_state_next = S_CONV;
            S_CONV: if (r_conv_cnt == c_CONV_LAST) w_state_next = S_DONE;
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Counts cycles spent in conversion; parked at zero otherwise.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST)                  r_conv_cnt <= '0;
        else if (r_state == S_CONV) r_conv_cnt <= r_conv_cnt + c_CW'(1);
        else                        r_conv_cnt <= '0;
    end

    // Bit-cell array: cleared on reset, written from the write port when idle.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            for (int i = 0; i < numRows; i++) r_mem[i] <= '0;
        end else if (w_wr_ok) begin
            r_mem[WR_ADDR] <= WR_DATA;
        end
    end

    // Sense-amp read path and write-reject flag, one cycle of latency each.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_rd_valid <= RD_EN;
            r_wr_err   <= WR_EN && !w_wr_ok;
            if (RD_EN) r_rd_data <= w_rd_in_range ? r_mem[RD_ADDR] : '0;
        end
    end

    // Captures the row drive pattern and ADC shift when a start is accepted.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_pos   <= '0;
            r_neg   <= '0;
            r_shift <= '0;
        end else if (w_accept) begin
            r_pos   <= MAC_POS;
            r_neg   <= MAC_NEG;
            r_shift <= ADC_SHIFT;
        end
    end

    // Bit-line integration: +1 / -1 per stored one on a positively /
    // negatively driven row; a row driven both ways cancels to zero.
    always_comb begin
        for (int j = 0; j < numCols; j++) begin
            w_sum[j] = '0;
            for (int i = 0; i < numRows; i++) begin
                if (r_mem[i][j] && r_pos[i] && !r_neg[i])
                    w_sum[j] = w_sum[j] + c_ONE;
                else if (r_mem[i][j] && r_neg[i] && !r_pos[i])
                    w_sum[j] = w_sum[j] - c_ONE;
            end
        end
    end

    // Holds the integrated column charge from the INT cycle through conversion.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            for (int j = 0; j < numCols; j++) r_sum[j] <= '0;
        end else if (r_state == S_INT) begin
            for (int j = 0; j < numCols; j++) r_sum[j] <= w_sum[j];
        end
    end

    // ADC transfer: arithmetic right shift (floor), then clamp to code range.
    always_comb begin
        w_code = '0;
        for (int j = 0; j < numCols; j++) begin
            w_shr[j] = r_sum[j] >>> r_shift;
            if (w_shr[j] > c_CODE_MAX)
                w_code[j*numAdcBits +: numAdcBits] = c_CODE_MAX[numAdcBits-1:0];
            else if (w_shr[j] < c_CODE_MIN)
                w_code[j*numAdcBits +: numAdcBits] = c_CODE_MIN[numAdcBits-1:0];
            else
                w_code[j*numAdcBits +: numAdcBits] = w_shr[j][numAdcBits-1:0];
        end
    end

    // Result register: loaded on the edge that enters DONE, held until the next.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST)                                          r_adc_out <= '0;
        else if (r_state == S_CONV && w_state_next == S_DONE) r_adc_out <= w_code;
    end

    assign WR_ERR   = r_wr_err;
    assign RD_DATA  = r_rd_data;
    assign RD_VALID = r_rd_valid;
    assign MAC_BUSY = w_busy;
    assign MAC_DONE = w_done;
    assign ADC_OUT  = r_adc_out;

endmodule
`default_nettype wire

// File: tb/tb_ts_array_model.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ts_array_model
//  Purpose  : Self-checking bench for ts_array_model against a plain
//             integer model of the array and its ADC transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ts_array_model;

    logic         CLK = 1'b0;
    logic         NRST = 1'b0;
    logic         WR_EN = 1'b0;
    logic [6:0]   WR_ADDR = '0;
    logic [7:0]   WR_DATA = '0;
    logic         WR_ERR;
    logic         RD_EN = 1'b0;
    logic [6:0]   RD_ADDR = '0;
    logic [7:0]   RD_DATA;
    logic         RD_VALID;
    logic         MAC_START = 1'b0;
    logic [127:0] MAC_POS = '0;
    logic [127:0] MAC_NEG = '0;
    logic [3:0]   ADC_SHIFT = '0;
    logic         MAC_BUSY;
    logic         MAC_DONE;
    logic [31:0]  ADC_OUT;

    int checks = 0;
    int errors = 0;
    logic [7:0] mmem [128];

    ts_array_model dut (
        .CLK(CLK), .NRST(NRST),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_ERR(WR_ERR),
        .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
        .MAC_START(MAC_START), .MAC_POS(MAC_POS), .MAC_NEG(MAC_NEG),
        .ADC_SHIFT(ADC_SHIFT), .MAC_BUSY(MAC_BUSY), .MAC_DONE(MAC_DONE),
        .ADC_OUT(ADC_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Column sum with integer weights, floor division by 2^shift, clamp to 4-bit.
    function automatic logic [31:0] model_adc(input logic [127:0] pos, input logic [127:0] neg,
                                              input int sh);
        logic [31:0] r;
        int s, d, q;
        r = '0;
        d = 1 << sh;
        for (int j = 0; j < 8; j++) begin
            s = 0;
            for (int i = 0; i < 128; i++)
                if (mmem[i][j]) s += (pos[i] ? 1 : 0) - (neg[i] ? 1 : 0);
            if (s >= 0) q = s / d;
            else        q = -((-s + d - 1) / d);
            if (q > 7)  q = 7;
            if (q < -8) q = -8;
            r[j*4 +: 4] = q[3:0];
        end
        return r;
    endfunction

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
        tick;
        WR_EN = 1'b0;
        mmem[a] = d;
        chk("wr_err_idle", WR_ERR, 0);
    endtask

    task automatic do_read(input string tag, input logic [6:0] a);
        logic [7:0] exp;
        exp = mmem[a];
        RD_EN = 1'b1; RD_ADDR = a;
        tick;
        RD_EN = 1'b0;
        chk({tag, "_valid"}, RD_VALID, 1);
        chk({tag, "_data"}, RD_DATA, exp);
        RD_ADDR = ~a;
        tick;
        chk({tag, "_valid_low"}, RD_VALID, 0);
        chk({tag, "_hold"}, RD_DATA, exp);
    endtask

    task automatic run_mac(input string tag, input logic [127:0] pos, input logic [127:0] neg,
                           input logic [3:0] sh);
        logic [31:0] exp;
        int n;
        exp = model_adc(pos, neg, int'(sh));
        MAC_POS = pos; MAC_NEG = neg; ADC_SHIFT = sh; MAC_START = 1'b1;
        tick;
        MAC_START = 1'b0;
        MAC_POS = ~pos; MAC_NEG = '0; ADC_SHIFT = ~sh;
        chk({tag, "_busy"}, MAC_BUSY, 1);
        n = 1;
        while (MAC_DONE !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_latency"}, n, 5);
        chk({tag, "_adc"}, ADC_OUT, exp);
        tick;
        chk({tag, "_done_low"}, MAC_DONE, 0);
        chk({tag, "_idle"}, MAC_BUSY, 0);
        chk({tag, "_adc_hold"}, ADC_OUT, exp);
    endtask

    initial begin
        logic [31:0] rp, rn, exp_adc;
        logic [6:0]  ra;
        int          dones;

        for (int i = 0; i < 128; i++) mmem[i] = '0;

        // Reset values
        repeat (2) tick;
        chk("rst_adc", ADC_OUT, 0);
        chk("rst_rd_data", RD_DATA, 0);
        chk("rst_rd_valid", RD_VALID, 0);
        chk("rst_wr_err", WR_ERR, 0);
        chk("rst_busy", MAC_BUSY, 0);
        chk("rst_done", MAC_DONE, 0);
        NRST = 1'b1;
        tick;

        // Saturating positive and negative drives
        for (int r = 0; r < 10; r++) do_write(7'(r), 8'hFF);
        run_mac("pos_sh0", 128'h3FF, 128'h0, 4'd0);
        chk("pos_sh0_lit", ADC_OUT, 32'h7777_7777);
        run_mac("pos_sh1", 128'h3FF, 128'h0, 4'd1);
        chk("pos_sh1_lit", ADC_OUT, 32'h5555_5555);
        run_mac("neg_sh0", 128'h0, 128'h3FF, 4'd0);
        chk("neg_sh0_lit", ADC_OUT, 32'h8888_8888);
        run_mac("neg_sh2", 128'h0, 128'h3FF, 4'd2);
        chk("neg_sh2_lit", ADC_OUT, 32'hDDDD_DDDD);

        // Row driven both ways cancels; +1/-1 on the same row cancels
        do_write(7'd3, 8'h0F);
        do_write(7'd4, 8'hF0);
        run_mac("cancel", 128'h18, 128'h18, 4'd0);
        chk("cancel_lit", ADC_OUT, 32'h0);

        // Read port, including read-during-write to the same row
        do_write(7'd5, 8'hA5);
        do_read("rd5", 7'd5);
        WR_EN = 1'b1; WR_ADDR = 7'd5; WR_DATA = 8'h5A;
        RD_EN = 1'b1; RD_ADDR = 7'd5;
        tick;
        WR_EN = 1'b0; RD_EN = 1'b0;
        chk("rdw_old_data", RD_DATA, 8'hA5);
        chk("rdw_valid", RD_VALID, 1);
        mmem[5] = 8'h5A;
        do_read("rd5_new", 7'd5);

        // Write and start requests while busy are dropped
        exp_adc = model_adc(128'h3FF, 128'h0, 0);
        MAC_POS = 128'h3FF; MAC_NEG = '0; ADC_SHIFT = 4'd0; MAC_START = 1'b1;
        tick;                                   // PRE
        MAC_START = 1'b0;
        tick;                                   // INT
        tick;                                   // CONV, first cycle
        WR_EN = 1'b1; WR_ADDR = 7'd20; WR_DATA = 8'h33;
        tick;                                   // CONV, second cycle
        WR_EN = 1'b0;
        chk("busy_wr_err", WR_ERR, 1);
        chk("busy_conv", MAC_BUSY, 1);
        MAC_START = 1'b1;
        tick;                                   // DONE
        MAC_START = 1'b0;
        chk("busy_done", MAC_DONE, 1);
        chk("busy_wr_err_pulse", WR_ERR, 0);
        chk("busy_adc", ADC_OUT, exp_adc);
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (MAC_DONE === 1'b1) dones++;
        end
        chk("ignored_start_no_done", dones, 0);
        chk("ignored_start_idle", MAC_BUSY, 0);
        do_read("busy_row_kept", 7'd20);

        // Randomized writes and MACs on the low 32 rows
        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 3; w++) do_write(7'($urandom_range(0, 31)), 8'($urandom));
            rp = $urandom & $urandom;
            rn = $urandom & $urandom;
            run_mac("rand_mac", {96'h0, rp}, {96'h0, rn}, 4'($urandom_range(0, 4)));
            ra = 7'($urandom_range(0, 31));
            do_read("rand_rd", ra);
        end

        // Asynchronous reset in the middle of integration
        for (int r = 0; r < 10; r++) do_write(7'(r), 8'hFF);
        run_mac("pre_reset", 128'h3FF, 128'h0, 4'd0);
        MAC_POS = 128'h3FF; MAC_START = 1'b1;
        tick;                                   // PRE
        MAC_START = 1'b0;
        tick;                                   // INT
        #2 NRST = 1'b0;
        #1;
        chk("arst_busy", MAC_BUSY, 0);
        chk("arst_adc", ADC_OUT, 0);
        chk("arst_done", MAC_DONE, 0);
        for (int i = 0; i < 128; i++) mmem[i] = '0;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (MAC_DONE === 1'b1) dones++;
            if (c == 2) NRST = 1'b1;
        end
        chk("arst_no_done", dones, 0);
        do_read("arst_rd0", 7'd0);
        do_read("arst_rd5", 7'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
